// File: rtl/controlador_booth.sv
// Sequencer for the radix-2 Booth multiplier datapath: load, add/subtract, shift, done.
// Optional completed-operation counter enabled by defining CONTADOR_OPERACIONES_EN.
module controlador_booth #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          reloj,
  input  logic          reinicio,
  input  logic          inicio,
  input  logic [1:0]    q_lsb,
  output logic          cargar,
  output logic          sumar,
  output logic          restar,
  output logic          desplazar,
  output logic          ocupado,
  output logic          listo,
  output logic [CW-1:0] iteracion
`ifdef CONTADOR_OPERACIONES_EN
  ,
  output logic [15:0]   operaciones
`endif
);

  localparam logic [2:0] REPOSO   = 3'd0;
  localparam logic [2:0] CARGA    = 3'd1;
  localparam logic [2:0] EVALUA   = 3'd2;
  localparam logic [2:0] DESPLAZA = 3'd3;
  localparam logic [2:0] FIN      = 3'd4;

  localparam logic [CW-1:0] ULTIMA = CW'(N - 1);

  logic [2:0]    estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic          cargar_q, evalua_q, desplazar_q, ocupado_q, listo_q;

  always_comb begin
    estado_d = REPOSO;
    cont_d   = cont_q;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          estado_d = CARGA;
          cont_d   = '0;
        end else begin
          estado_d = REPOSO;
        end
      end
      CARGA:    estado_d = EVALUA;
      EVALUA:   estado_d = DESPLAZA;
      DESPLAZA: begin
        cont_d   = cont_q + 1'b1;
        estado_d = (cont_q == ULTIMA) ? FIN : EVALUA;
      end
      FIN:      estado_d = REPOSO;
      default:  estado_d = REPOSO;
    endcase
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      estado_q    <= REPOSO;
      cont_q      <= '0;
      cargar_q    <= 1'b0;
      evalua_q    <= 1'b0;
      desplazar_q <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      cargar_q    <= (estado_d == CARGA);
      evalua_q    <= (estado_d == EVALUA);
      desplazar_q <= (estado_d == DESPLAZA);
      ocupado_q   <= (estado_d != REPOSO);
      listo_q     <= (estado_d == FIN);
    end
  end

  // q_lsb only becomes valid after the load, so add/subtract are gated by the EVALUA flop.
  assign sumar     = evalua_q & (q_lsb == 2'b01);
  assign restar    = evalua_q & (q_lsb == 2'b10);
  assign cargar    = cargar_q;
  assign desplazar = desplazar_q;
  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign iteracion = cont_q;

`ifdef CONTADOR_OPERACIONES_EN
  logic [15:0] operaciones_q;

  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      operaciones_q <= '0;
    end else if (estado_d == FIN) begin
      operaciones_q <= operaciones_q + 16'd1;
    end
  end

  assign operaciones = operaciones_q;
`endif

endmodule

// File: tb/tb_controlador_booth.sv
// Directed bench for controlador_booth with a behavioural Booth datapath model.
module tb_controlador_booth;
  localparam int N = 8;

  logic       reloj = 1'b0;
  logic       reinicio;
  logic       inicio;
  logic [1:0] q_lsb;
  logic [1:0] q_drv;
  logic       use_model;
  logic       cargar, sumar, restar, desplazar, ocupado, listo;
  logic [3:0] iteracion;
`ifdef CONTADOR_OPERACIONES_EN
  logic [15:0] operaciones;
`endif

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;

  controlador_booth #(.N(N)) dut (
    .reloj     (reloj),
    .reinicio  (reinicio),
    .inicio    (inicio),
    .q_lsb     (q_lsb),
    .cargar    (cargar),
    .sumar     (sumar),
    .restar    (restar),
    .desplazar (desplazar),
    .ocupado   (ocupado),
    .listo     (listo),
    .iteracion (iteracion)
`ifdef CONTADOR_OPERACIONES_EN
    ,
    .operaciones (operaciones)
`endif
  );

  always #5 reloj = ~reloj;

  // Datapath model: 9-bit accumulator so that -(-128) does not overflow.
  logic [7:0] ma, mb, mq;
  logic [8:0] macc;
  logic       mq1;
  always @(posedge reloj) begin
    if (cargar) begin
      macc <= '0;
      mq   <= mb;
      mq1  <= 1'b0;
    end else if (sumar) begin
      macc <= macc + {ma[7], ma};
    end else if (restar) begin
      macc <= macc - {ma[7], ma};
    end else if (desplazar) begin
      {macc, mq, mq1} <= {macc[8], macc, mq};
    end
  end
  wire [15:0] y_model = {macc[7:0], mq};

  assign q_lsb = use_model ? {mq[0], mq1} : q_drv;

  always @(negedge reloj) if (sumar && restar) both_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(output bit ok, output int at);
    inicio = 1'b1;
    ok = 1'b0;
    at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge reloj);
      if (k == 1) inicio = 1'b0;
      if (listo) begin
        ok = 1'b1;
        at = k;
        break;
      end
    end
    @(negedge reloj);
  endtask

  task automatic test_reset;
    reinicio = 1'b1; inicio = 1'b0; q_drv = 2'b00; use_model = 1'b0;
    mb = '0; ma = '0;
    repeat (2) @(negedge reloj);
    checks++;
    if ({cargar, sumar, restar, desplazar, ocupado, listo, iteracion} !== 10'd0)
      begin errors++; $display("FAIL reset_outputs: got %b expected 0",
        {cargar, sumar, restar, desplazar, ocupado, listo, iteracion}); end
    reinicio = 1'b0;
    repeat (2) @(negedge reloj);
    checks++;
    if ({ocupado, cargar} !== 2'b00)
      begin errors++; $display("FAIL idle_after_reset: ocupado,cargar=%b expected 00", {ocupado, cargar}); end
  endtask

  task automatic test_basic;
    int n_carg = 0, carg_at = 0, n_sr = 0, n_desp = 0, bad_desp = 0;
    int n_listo = 0, listo_at = 0, bad_occ = 0;
    logic [3:0] it_listo = '0;
    q_drv = 2'b00; use_model = 1'b0;
    inicio = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge reloj);
      if (k == 1) inicio = 1'b0;
      if (cargar) begin n_carg++; carg_at = k; end
      if (sumar || restar) n_sr++;
      if (desplazar) begin
        n_desp++;
        if (!((k % 2 == 1) && k >= 3 && k <= 17)) bad_desp++;
      end
      if (listo) begin n_listo++; listo_at = k; it_listo = iteracion; end
      if (ocupado !== (k <= 18)) bad_occ++;
    end
    checks++; if (n_carg != 1 || carg_at != 1)
      begin errors++; $display("FAIL basic_cargar: count=%0d at=%0d expected 1 at 1", n_carg, carg_at); end
    checks++; if (n_sr != 0)
      begin errors++; $display("FAIL basic_no_addsub: got %0d expected 0", n_sr); end
    checks++; if (n_desp != N)
      begin errors++; $display("FAIL basic_shift_count: got %0d expected %0d", n_desp, N); end
    checks++; if (bad_desp != 0)
      begin errors++; $display("FAIL basic_shift_position: %0d misplaced expected 0", bad_desp); end
    checks++; if (n_listo != 1 || listo_at != 18)
      begin errors++; $display("FAIL basic_listo: count=%0d at=%0d expected 1 at 18", n_listo, listo_at); end
    checks++; if (it_listo !== 4'd8)
      begin errors++; $display("FAIL basic_iter_at_listo: got %0d expected 8", it_listo); end
    checks++; if (bad_occ != 0)
      begin errors++; $display("FAIL basic_ocupado: %0d wrong cycles expected 0", bad_occ); end
    checks++; if (iteracion !== 4'd8)
      begin errors++; $display("FAIL basic_iter_idle: got %0d expected 8", iteracion); end
  endtask

  task automatic test_booth(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_y, input string name);
    bit ok; int at;
    use_model = 1'b1; ma = a; mb = b;
    run_op(ok, at);
    checks++;
    if (!ok || at != 18)
      begin errors++; $display("FAIL booth_%s_latency: listo seen=%0d at=%0d expected at 18", name, ok, at); end
    checks++;
    if (y_model !== exp_y)
      begin errors++; $display("FAIL booth_%s_product: got %h expected %h", name, y_model, exp_y); end
    use_model = 1'b0;
  endtask

  task automatic test_pattern;
    logic [1:0] pat [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] exp_sr [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    int bad_x = 0;
    bit seen = 1'b0;
    use_model = 1'b0;
    q_drv = 2'bxx;
    inicio = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge reloj);
      if (k == 1) inicio = 1'b0;
      if (listo) seen = 1'b1;
      if (k % 2 == 0 && k <= 8) begin
        checks++;
        if ({sumar, restar} !== exp_sr[k/2-1])
          begin errors++; $display("FAIL pattern_eval%0d: sumar,restar=%b expected %b",
            k/2, {sumar, restar}, exp_sr[k/2-1]); end
        q_drv = 2'bxx;
      end else if (k % 2 == 1 && k <= 9) begin
        if ({sumar, restar} !== 2'b00) bad_x++;
        q_drv = ((k - 1) / 2 < 4) ? pat[(k-1)/2] : 2'b00;
      end
    end
    checks++; if (bad_x != 0)
      begin errors++; $display("FAIL pattern_x_isolation: %0d bad cycles expected 0", bad_x); end
    checks++; if (!seen)
      begin errors++; $display("FAIL pattern_listo: listo not seen expected 1"); end
    checks++; if (both_cnt != 0)
      begin errors++; $display("FAIL sumar_restar_exclusive: %0d overlaps expected 0", both_cnt); end
    q_drv = 2'b00;
  endtask

  task automatic test_reset_midop;
    bit ok; int at;
    q_drv = 2'b01; use_model = 1'b0;
    inicio = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge reloj);
      if (k == 1) inicio = 1'b0;
    end
    checks++;
    if (sumar !== 1'b1)
      begin errors++; $display("FAIL midop_third_eval: sumar=%b expected 1", sumar); end
    reinicio = 1'b1;
    #1;
    checks++;
    if ({cargar, sumar, restar, desplazar, ocupado, listo, iteracion} !== 10'd0)
      begin errors++; $display("FAIL midop_async_reset: got %b expected 0",
        {cargar, sumar, restar, desplazar, ocupado, listo, iteracion}); end
    @(negedge reloj);
    reinicio = 1'b0;
    inicio = 1'b1;
    @(negedge reloj);
    inicio = 1'b0;
    checks++;
    if ({cargar, ocupado, iteracion} !== 6'b110000)
      begin errors++; $display("FAIL midop_restart: cargar,ocupado,iter=%b expected 110000",
        {cargar, ocupado, iteracion}); end
    ok = 1'b0; at = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge reloj);
      if (listo && !ok) begin ok = 1'b1; at = k; end
    end
    checks++;
    if (!ok || at != 18)
      begin errors++; $display("FAIL midop_restart_listo: seen=%0d at=%0d expected at 18", ok, at); end
    q_drv = 2'b00;
  endtask

  task automatic test_back_to_back;
    int n_carg = 0, n_listo = 0, n_carg2 = 0, listo2 = 0;
    int cpos [3] = '{0, 0, 0};
    int lpos [3] = '{0, 0, 0};
    q_drv = 2'b00; use_model = 1'b0;
    inicio = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge reloj);
      if (cargar) begin if (n_carg < 3) cpos[n_carg] = k; n_carg++; end
      if (listo)  begin if (n_listo < 3) lpos[n_listo] = k; n_listo++; end
      if (k == 40) inicio = 1'b0;
    end
    checks++;
    if (n_carg != 3 || cpos[0] != 1 || cpos[1] != 20 || cpos[2] != 39)
      begin errors++; $display("FAIL b2b_cargar: n=%0d at %0d,%0d,%0d expected 3 at 1,20,39",
        n_carg, cpos[0], cpos[1], cpos[2]); end
    checks++;
    if (n_listo != 3 || lpos[0] != 18 || lpos[1] != 37 || lpos[2] != 56)
      begin errors++; $display("FAIL b2b_listo: n=%0d at %0d,%0d,%0d expected 3 at 18,37,56",
        n_listo, lpos[0], lpos[1], lpos[2]); end
    inicio = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge reloj);
      inicio = (k == 4 || k == 5 || k == 9 || k == 16);
      if (cargar) n_carg2++;
      if (listo) listo2 = k;
    end
    checks++;
    if (n_carg2 != 1 || listo2 != 18)
      begin errors++; $display("FAIL ignored_start: cargar=%0d listo_at=%0d expected 1 and 18", n_carg2, listo2); end
  endtask

`ifdef CONTADOR_OPERACIONES_EN
  task automatic test_contador;
    bit ok, ok_all; int at;
    ok_all = 1'b1;
    reinicio = 1'b1; q_drv = 2'b00; use_model = 1'b0;
    @(negedge reloj);
    reinicio = 1'b0;
    checks++;
    if (operaciones !== 16'd0)
      begin errors++; $display("FAIL ops_reset: got %h expected 0000", operaciones); end
    for (int i = 0; i < 3; i++) begin run_op(ok, at); ok_all &= ok; end
    checks++;
    if (operaciones !== 16'd3 || !ok_all)
      begin errors++; $display("FAIL ops_three: got %h ops_ok=%0d expected 0003", operaciones, ok_all); end
    force dut.operaciones_q = 16'hFFFE;
    #1;
    release dut.operaciones_q;
    run_op(ok, at);
    checks++;
    if (operaciones !== 16'hFFFF || !ok)
      begin errors++; $display("FAIL ops_pre_wrap: got %h expected ffff", operaciones); end
    run_op(ok, at);
    checks++;
    if (operaciones !== 16'h0000 || !ok)
      begin errors++; $display("FAIL ops_wrap: got %h expected 0000", operaciones); end
    run_op(ok, at);
    inicio = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge reloj);
      if (k == 1) inicio = 1'b0;
    end
    checks++;
    if (operaciones !== 16'd1 || !ok)
      begin errors++; $display("FAIL ops_midop_hold: got %h expected 0001", operaciones); end
    reinicio = 1'b1;
    #1;
    checks++;
    if (operaciones !== 16'd0)
      begin errors++; $display("FAIL ops_reset_clear: got %h expected 0000", operaciones); end
    @(negedge reloj);
    reinicio = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_booth(8'd3,  8'd5,  16'd15,   "3x5");
    test_booth(8'hFD, 8'd7,  16'hFFEB, "m3x7");
    test_booth(8'h80, 8'h80, 16'h4000, "m128sq");
    test_pattern();
    test_reset_midop();
    test_back_to_back();
`ifdef CONTADOR_OPERACIONES_EN
    test_contador();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
